// File: rtl/vld_rdy_upsizer_nw.sv
// ============================================================================
// Module      : vld_rdy_upsizer_nw
// Description : Valid/ready width upsizer packing RATIO narrow beats into one
//               wide word, with early termination, keep mask and double buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vld_rdy_upsizer_nw #(
    parameter int DATA_WIDTH      = 32,
    parameter int RATIO           = 2,
    parameter int ORDER_MSB_FIRST = 0,
    parameter int CNT_WIDTH       = $clog2(RATIO)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_WIDTH-1:0]       s_data,
    input  logic                        s_last,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [RATIO*DATA_WIDTH-1:0] m_data,
    output logic [RATIO-1:0]            m_keep,
    output logic                        m_last
);

    localparam int                   WORD_WIDTH = RATIO * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = CNT_WIDTH'(RATIO - 1);

    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  lane;
    logic [WORD_WIDTH-1:0] asm_data;
    logic [WORD_WIDTH-1:0] asm_data_nxt;
    logic [RATIO-1:0]      asm_keep;
    logic [RATIO-1:0]      asm_keep_nxt;
    logic                  asm_last;
    logic                  pend;
    logic                  accept;
    logic                  complete;
    logic                  out_free;

    assign s_ready  = ~pend;
    assign accept   = s_valid & ~pend;
    assign complete = accept & (s_last | (cnt == CNT_MAX));
    assign out_free = ~m_valid | m_ready;
    assign lane     = (ORDER_MSB_FIRST != 0) ? (CNT_MAX - cnt) : cnt;

    // Assembly contents as they would look with the current beat merged in.
    always_comb begin
        asm_data_nxt = asm_data;
        asm_keep_nxt = asm_keep;
        for (int i = 0; i < RATIO; i++) begin
            if (lane == CNT_WIDTH'(i)) begin
                asm_data_nxt[i*DATA_WIDTH +: DATA_WIDTH] = s_data;
                asm_keep_nxt[i]                          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt      <= '0;
            asm_data <= '0;
            asm_keep <= '0;
            asm_last <= 1'b0;
            pend     <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_keep   <= '0;
            m_last   <= 1'b0;
        end else if (pend) begin
            // A frozen word waits here; no beats are accepted meanwhile.
            if (out_free) begin
                m_valid  <= 1'b1;
                m_data   <= asm_data;
                m_keep   <= asm_keep;
                m_last   <= asm_last;
                pend     <= 1'b0;
                asm_data <= '0;
                asm_keep <= '0;
                asm_last <= 1'b0;
            end
        end else if (complete) begin
            cnt <= '0;
            if (out_free) begin
                m_valid  <= 1'b1;
                m_data   <= asm_data_nxt;
                m_keep   <= asm_keep_nxt;
                m_last   <= s_last;
                asm_data <= '0;
                asm_keep <= '0;
            end else begin
                pend     <= 1'b1;
                asm_data <= asm_data_nxt;
                asm_keep <= asm_keep_nxt;
                asm_last <= s_last;
            end
        end else begin
            if (accept) begin
                cnt      <= cnt + 1'b1;
                asm_data <= asm_data_nxt;
                asm_keep <= asm_keep_nxt;
            end
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
